// File: rtl/utm_engine_if.sv
// Bus bundle for utm_engine: program port, tape load, run handshake and live machine outputs.
// Optional UTM_SINGLE_STEP_EN adds the step_en qualifier to the bundle.
interface utm_engine_if #(
    parameter int TAPE_LEN = 16,
    parameter int STATE_W  = 3,
    parameter int STEP_W   = 12,
    parameter int HW       = $clog2(TAPE_LEN)
) ();
    logic                 prog_we;
    logic [STATE_W:0]     prog_addr;
    logic [STATE_W+3:0]   prog_data;
    logic                 load;
    logic [TAPE_LEN-1:0]  tape_in;
    logic [HW-1:0]        head_init;
    logic                 start;
`ifdef UTM_SINGLE_STEP_EN
    logic                 step_en;
`endif
    logic                 busy;
    logic                 done;
    logic                 err_bounds;
    logic                 err_timeout;
    logic [TAPE_LEN-1:0]  tape_out;
    logic [HW-1:0]        head_pos;
    logic [STATE_W-1:0]   state_out;
    logic [STEP_W-1:0]    step_cnt;

    modport master (
        output prog_we, prog_addr, prog_data, load, tape_in, head_init, start,
`ifdef UTM_SINGLE_STEP_EN
        output step_en,
`endif
        input  busy, done, err_bounds, err_timeout, tape_out, head_pos, state_out, step_cnt
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, load, tape_in, head_init, start,
`ifdef UTM_SINGLE_STEP_EN
        input  step_en,
`endif
        output busy, done, err_bounds, err_timeout, tape_out, head_pos, state_out, step_cnt
    );
endinterface

// File: rtl/utm_engine.sv
// Programmable single-tape binary Turing machine: loadable transition table, one transition per enabled RUN cycle.
// Define UTM_SINGLE_STEP_EN to gate transitions with bus.step_en.
module utm_engine #(
    parameter int TAPE_LEN = 16,
    parameter int STATE_W  = 3,
    parameter int STEP_W   = 12,
    parameter int HW       = $clog2(TAPE_LEN)
) (
    input  logic         clk,
    input  logic         rst_n,
    utm_engine_if.slave  bus
);
    localparam int ENT_W = STATE_W + 4;
    localparam int NENT  = 2 ** (STATE_W + 1);

    typedef enum logic {S_IDLE, S_RUN} fsm_e;

    fsm_e                fsm_q, fsm_d;
    logic [TAPE_LEN-1:0] tape_q, tape_d;
    logic [HW-1:0]       head_q, head_d;
    logic [STATE_W-1:0]  st_q, st_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                done_q, done_d;
    logic                eb_q, eb_d;
    logic                et_q, et_d;
    logic [ENT_W-1:0]    table_q [NENT];

    logic                sym;
    logic [ENT_W-1:0]    ent;
    logic                e_halt;
    logic [1:0]          e_move;
    logic                e_wsym;
    logic [STATE_W-1:0]  e_next;
    logic [STEP_W-1:0]   step_inc;
    logic                hit_lo, hit_hi, fault, limit_hit;
    logic                step_go;
    logic [HW-1:0]       head_clamp;

`ifdef UTM_SINGLE_STEP_EN
    assign step_go = bus.step_en;
`else
    assign step_go = 1'b1;
`endif

    // Combinational table lookup for the cell under the head
    assign sym       = tape_q[head_q];
    assign ent       = table_q[{st_q, sym}];
    assign e_halt    = ent[STATE_W+3];
    assign e_move    = ent[STATE_W+2:STATE_W+1];
    assign e_wsym    = ent[STATE_W];
    assign e_next    = ent[STATE_W-1:0];
    assign step_inc  = step_q + STEP_W'(1);
    assign hit_lo    = (e_move == 2'b10) && (head_q == '0);
    assign hit_hi    = (e_move == 2'b01) && (head_q == HW'(TAPE_LEN - 1));
    assign fault     = !e_halt && (hit_lo || hit_hi);
    assign limit_hit = !e_halt && (step_inc == '1);

    always_comb begin
        head_clamp = bus.head_init;
        if (int'(bus.head_init) >= TAPE_LEN) head_clamp = HW'(TAPE_LEN - 1);
    end

    always_comb begin
        fsm_d  = fsm_q;
        tape_d = tape_q;
        head_d = head_q;
        st_d   = st_q;
        step_d = step_q;
        done_d = 1'b0;
        eb_d   = eb_q;
        et_d   = et_q;
        case (fsm_q)
            S_IDLE: begin
                if (bus.load) begin
                    tape_d = bus.tape_in;
                    head_d = head_clamp;
                end else if (bus.start) begin
                    step_d = '0;
                    eb_d   = 1'b0;
                    et_d   = 1'b0;
                    st_d   = '0;
                    fsm_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (step_go) begin
                    tape_d[head_q] = e_wsym;
                    step_d         = step_inc;
                    if (e_halt) begin
                        done_d = 1'b1;
                        fsm_d  = S_IDLE;
                    end else begin
                        // A fault keeps head and state; only the write lands
                        if (fault) begin
                            eb_d = 1'b1;
                        end else begin
                            st_d = e_next;
                            if (e_move == 2'b01) head_d = head_q + HW'(1);
                            else if (e_move == 2'b10) head_d = head_q - HW'(1);
                        end
                        if (limit_hit) et_d = 1'b1;
                        if (fault || limit_hit) begin
                            done_d = 1'b1;
                            fsm_d  = S_IDLE;
                        end
                    end
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q  <= S_IDLE;
            tape_q <= '0;
            head_q <= '0;
            st_q   <= '0;
            step_q <= '0;
            done_q <= 1'b0;
            eb_q   <= 1'b0;
            et_q   <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            tape_q <= tape_d;
            head_q <= head_d;
            st_q   <= st_d;
            step_q <= step_d;
            done_q <= done_d;
            eb_q   <= eb_d;
            et_q   <= et_d;
        end
    end

    // Program store; reset wipes it so a restart without reprogramming runs the all-zero machine
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++) table_q[i] <= '0;
        end else if (bus.prog_we && (fsm_q == S_IDLE)) begin
            table_q[bus.prog_addr] <= bus.prog_data;
        end
    end

    assign bus.busy        = (fsm_q == S_RUN);
    assign bus.done        = done_q;
    assign bus.err_bounds  = eb_q;
    assign bus.err_timeout = et_q;
    assign bus.tape_out    = tape_q;
    assign bus.head_pos    = head_q;
    assign bus.state_out   = st_q;
    assign bus.step_cnt    = step_q;
endmodule

// File: tb/tb_utm_engine.sv
// Self-checking bench for utm_engine: directed adder scenarios plus random programs against a step-loop model.
module tb_utm_engine;
    localparam int TL      = 16;
    localparam int SW      = 3;
    localparam int PW      = 12;
    localparam int MAXSTEP = 4095;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [6:0] m_prog [16];

    always #5 clk = ~clk;

    utm_engine_if #(.TAPE_LEN(TL), .STATE_W(SW), .STEP_W(PW)) bus ();
    utm_engine #(.TAPE_LEN(TL), .STATE_W(SW), .STEP_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: run the machine rule by rule until halt, edge fault or step limit
    task automatic model_run(input logic [15:0] t_in, input logic [3:0] h_in,
                             output logic [15:0] t_o, output int h_o, output int s_o,
                             output int n_o, output bit eb_o, output bit et_o);
        logic [15:0] t;
        logic [6:0]  e;
        int h, s, n;
        bit fin;
        t = t_in; h = int'(h_in); s = 0; n = 0; eb_o = 0; et_o = 0; fin = 0;
        while (!fin) begin
            e = m_prog[s * 2 + int'(t[h])];
            t[h] = e[3];
            n++;
            if (e[6]) fin = 1;
            else begin
                if ((e[5:4] == 2'b01 && h == TL - 1) || (e[5:4] == 2'b10 && h == 0)) begin
                    eb_o = 1; fin = 1;
                end else begin
                    if (e[5:4] == 2'b01) h++;
                    else if (e[5:4] == 2'b10) h--;
                    s = int'(e[2:0]);
                end
                if (n == MAXSTEP) begin et_o = 1; fin = 1; end
            end
        end
        t_o = t; h_o = h; s_o = s; n_o = n;
    endtask

    task automatic prog_write(input logic [3:0] a, input logic [6:0] d);
        bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
        m_prog[a] = d;
        @(negedge clk);
        bus.prog_we = 1'b0;
    endtask

    task automatic prog_adder();
        prog_write(4'd1, 7'h18);
        prog_write(4'd0, 7'h19);
        prog_write(4'd3, 7'h19);
        prog_write(4'd2, 7'h22);
        prog_write(4'd4, 7'h40);
        prog_write(4'd5, 7'h40);
    endtask

    task automatic do_run(input logic [15:0] t, input logic [3:0] h, input int limit,
                          output int cyc, output bit ok, output logic busy_after);
        bus.load = 1'b1; bus.tape_in = t; bus.head_init = h;
        @(negedge clk);
        bus.load = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        busy_after = bus.busy;
        cyc = 0; ok = 0;
        while (!ok && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) ok = 1;
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err_bounds !== 1'b0 || bus.err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl got busy=%b done=%b eb=%b et=%b want all 0",
                               bus.busy, bus.done, bus.err_bounds, bus.err_timeout);
        end
        n_tests++;
        if (bus.tape_out !== 16'h0 || bus.head_pos !== 4'h0 || bus.state_out !== 3'h0 || bus.step_cnt !== 12'h0) begin
            n_fail++; $display("FAIL reset_data got tape=%h head=%0d st=%0d step=%0d want zeros",
                               bus.tape_out, bus.head_pos, bus.state_out, bus.step_cnt);
        end
    endtask

    task automatic test_adder();
        int cyc; bit ok; logic b;
        prog_adder();
        do_run(16'h0037, 4'd0, 100, cyc, ok, b);
        n_tests++;
        if (b !== 1'b1) begin n_fail++; $display("FAIL adder_busy got %b want 1", b); end
        n_tests++;
        if (!ok || cyc != 8) begin n_fail++; $display("FAIL adder_latency got ok=%0d cyc=%0d want 8", ok, cyc); end
        n_tests++;
        if (bus.tape_out !== 16'h001F || bus.head_pos !== 4'd5 || bus.state_out !== 3'd2 || bus.step_cnt !== 12'd8) begin
            n_fail++; $display("FAIL adder_result got tape=%h head=%0d st=%0d step=%0d want 001f 5 2 8",
                               bus.tape_out, bus.head_pos, bus.state_out, bus.step_cnt);
        end
        n_tests++;
        if (bus.busy !== 1'b0 || bus.err_bounds !== 1'b0 || bus.err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL adder_flags got busy=%b eb=%b et=%b want 0 0 0", bus.busy, bus.err_bounds, bus.err_timeout);
        end
        @(negedge clk);
        n_tests++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL adder_done_pulse got %b want 0", bus.done); end
    endtask

    task automatic test_adder_zero();
        int cyc; bit ok; logic b;
        do_run(16'h0000, 4'd0, 100, cyc, ok, b);
        n_tests++;
        if (!ok || cyc != 3 || bus.step_cnt !== 12'd3) begin
            n_fail++; $display("FAIL zero_steps got ok=%0d cyc=%0d step=%0d want 3", ok, cyc, bus.step_cnt);
        end
        n_tests++;
        if (bus.tape_out !== 16'h0000 || bus.head_pos !== 4'd0) begin
            n_fail++; $display("FAIL zero_result got tape=%h head=%0d want 0000 0", bus.tape_out, bus.head_pos);
        end
    endtask

    task automatic test_bounds();
        int cyc; bit ok; logic b;
        do_run(16'hFFFF, 4'd0, 100, cyc, ok, b);
        n_tests++;
        if (!ok || cyc != 16 || bus.step_cnt !== 12'd16) begin
            n_fail++; $display("FAIL bounds_steps got ok=%0d cyc=%0d step=%0d want 16", ok, cyc, bus.step_cnt);
        end
        n_tests++;
        if (bus.err_bounds !== 1'b1 || bus.err_timeout !== 1'b0 || bus.head_pos !== 4'd15 || bus.tape_out !== 16'hFFFF) begin
            n_fail++; $display("FAIL bounds_result got eb=%b et=%b head=%0d tape=%h want 1 0 15 ffff",
                               bus.err_bounds, bus.err_timeout, bus.head_pos, bus.tape_out);
        end
        @(negedge clk);
        n_tests++;
        if (bus.done !== 1'b0 || bus.err_bounds !== 1'b1) begin
            n_fail++; $display("FAIL bounds_pulse got done=%b eb=%b want 0 1", bus.done, bus.err_bounds);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc; bit ok;
        bus.load = 1'b1; bus.tape_in = 16'h0037; bus.head_init = 4'd0;
        @(negedge clk);
        bus.load = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.load = 1'b1; bus.tape_in = 16'hA5A5; bus.head_init = 4'd9;
        bus.prog_we = 1'b1; bus.prog_addr = 4'd3; bus.prog_data = 7'h40;
        cyc = 0; ok = 0;
        while (!ok && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) begin bus.start = 1'b0; bus.load = 1'b0; bus.prog_we = 1'b0; end
            if (bus.done === 1'b1) ok = 1;
        end
        bus.start = 1'b0; bus.load = 1'b0; bus.prog_we = 1'b0;
        n_tests++;
        if (!ok || cyc != 8 || bus.tape_out !== 16'h001F || bus.head_pos !== 4'd5) begin
            n_fail++; $display("FAIL busy_ignore got ok=%0d cyc=%0d tape=%h head=%0d want 8 001f 5",
                               ok, cyc, bus.tape_out, bus.head_pos);
        end
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_restart got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_random();
        logic [15:0] t, et_tape;
        logic [3:0]  h;
        int eh, es, en, cyc;
        bit eeb, eet, ok;
        logic b;
        for (int it = 0; it < 10; it++) begin
            for (int a = 0; a < 16; a++)
                prog_write(4'(a), {($urandom_range(0, 3) == 0), 2'($urandom), 1'($urandom), 3'($urandom)});
            t = 16'($urandom);
            h = 4'($urandom);
            model_run(t, h, et_tape, eh, es, en, eeb, eet);
            do_run(t, h, 5000, cyc, ok, b);
            n_tests++;
            if (!ok || cyc != en) begin n_fail++; $display("FAIL rand%0d_len got ok=%0d cyc=%0d want %0d", it, ok, cyc, en); end
            n_tests++;
            if (bus.tape_out !== et_tape || int'(bus.head_pos) != eh || int'(bus.state_out) != es || int'(bus.step_cnt) != en) begin
                n_fail++; $display("FAIL rand%0d_state got tape=%h head=%0d st=%0d step=%0d want %h %0d %0d %0d",
                                   it, bus.tape_out, bus.head_pos, bus.state_out, bus.step_cnt, et_tape, eh, es, en);
            end
            n_tests++;
            if (bus.err_bounds !== logic'(eeb) || bus.err_timeout !== logic'(eet)) begin
                n_fail++; $display("FAIL rand%0d_err got eb=%b et=%b want %b %b", it, bus.err_bounds, bus.err_timeout, eeb, eet);
            end
        end
    endtask

    task automatic test_timeout();
        int cyc; bit ok; logic b;
        prog_write(4'd0, 7'h00);
        prog_write(4'd1, 7'h00);
        do_run(16'h00F0, 4'd4, 5000, cyc, ok, b);
        n_tests++;
        if (!ok || cyc != MAXSTEP || int'(bus.step_cnt) != MAXSTEP) begin
            n_fail++; $display("FAIL timeout_steps got ok=%0d cyc=%0d step=%0d want 4095", ok, cyc, bus.step_cnt);
        end
        n_tests++;
        if (bus.err_timeout !== 1'b1 || bus.err_bounds !== 1'b0 || bus.tape_out !== 16'h00E0 || bus.head_pos !== 4'd4) begin
            n_fail++; $display("FAIL timeout_result got et=%b eb=%b tape=%h head=%0d want 1 0 00e0 4",
                               bus.err_timeout, bus.err_bounds, bus.tape_out, bus.head_pos);
        end
    endtask

    task automatic test_reset_midrun();
        logic [15:0] et_tape;
        int eh, es, en, cyc;
        bit eeb, eet, ok;
        logic b;
        prog_adder();
        bus.load = 1'b1; bus.tape_in = 16'h0037; bus.head_init = 4'd0;
        @(negedge clk);
        bus.load = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.tape_out !== 16'h0 || bus.step_cnt !== 12'h0 || bus.head_pos !== 4'h0) begin
            n_fail++; $display("FAIL midrun_reset got busy=%b tape=%h step=%0d head=%0d want 0 0000 0 0",
                               bus.busy, bus.tape_out, bus.step_cnt, bus.head_pos);
        end
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) m_prog[a] = 7'h00;
        model_run(16'h0037, 4'd0, et_tape, eh, es, en, eeb, eet);
        do_run(16'h0037, 4'd0, 5000, cyc, ok, b);
        n_tests++;
        if (!ok || bus.err_timeout !== 1'b1 || int'(bus.step_cnt) != MAXSTEP || !eet) begin
            n_fail++; $display("FAIL midrun_cleared got ok=%0d et=%b step=%0d want timeout at 4095",
                               ok, bus.err_timeout, bus.step_cnt);
        end
        n_tests++;
        if (bus.tape_out !== et_tape || int'(bus.head_pos) != eh) begin
            n_fail++; $display("FAIL midrun_tape got tape=%h head=%0d want %h %0d", bus.tape_out, bus.head_pos, et_tape, eh);
        end
    endtask

`ifdef UTM_SINGLE_STEP_EN
    task automatic test_single_step();
        int cyc, pulses;
        bit ok;
        prog_adder();
        bus.load = 1'b1; bus.tape_in = 16'h0037; bus.head_init = 4'd0;
        @(negedge clk);
        bus.load = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0; pulses = 0; ok = 0;
        bus.step_en = 1'b0;
        while (!ok && cyc < 200) begin
            @(negedge clk);
            if (bus.done === 1'b1) ok = 1;
            else begin
                cyc++;
                bus.step_en = (cyc % 3 == 0);
                if (bus.step_en) pulses++;
            end
        end
        bus.step_en = 1'b1;
        n_tests++;
        if (!ok || pulses != 8 || bus.tape_out !== 16'h001F || bus.step_cnt !== 12'd8) begin
            n_fail++; $display("FAIL single_step got ok=%0d pulses=%0d tape=%h step=%0d want 8 001f 8",
                               ok, pulses, bus.tape_out, bus.step_cnt);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
        bus.load = 1'b0; bus.tape_in = '0; bus.head_init = '0; bus.start = 1'b0;
`ifdef UTM_SINGLE_STEP_EN
        bus.step_en = 1'b1;
`endif
        for (int a = 0; a < 16; a++) m_prog[a] = 7'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_adder();
        test_adder_zero();
        test_bounds();
        test_busy_ignore();
        test_random();
        test_timeout();
        test_reset_midrun();
`ifdef UTM_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
